// File: rtl/run_controller.sv
// Run sequencer for the single-cycle processor: start/ack handshake, run enable,
// PC start-address load, run-cycle counting and watchdog timeout.
module run_controller #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  prog_base,
  input  logic             done,
  output logic             run_en,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_value,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  // state  | meaning
  // IDLE   | after reset, waiting for the first start request
  // HOLD   | start high, prog_base tracked into pc_load_value
  // LOAD   | one-cycle pc_load pulse, cycle counter cleared
  // RUN    | processor enabled, counting cycles against the watchdog
  // FINISH | run over, ack held (timeout tells why) until the next start

  if (MAX_CYCLES < 1 || MAX_CYCLES > (2**CNT_W) - 1) begin : g_bad_max_cycles
    $error("run_controller: MAX_CYCLES must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {IDLE, HOLD, LOAD, RUN, FINISH} state_t;

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] count_next;

  assign count_next = cycle_count + 1'b1;

  // armed holds off the first edge after reset release so a start that is
  // already high at release cannot launch a run on that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      run_en        <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_value <= '0;
      ack           <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
    end else begin
      armed   <= 1'b1;
      pc_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start && armed) begin
            state         <= HOLD;
            pc_load_value <= prog_base;
          end
        end
        HOLD: begin
          if (start) begin
            pc_load_value <= prog_base;
          end else begin
            state       <= LOAD;
            pc_load     <= 1'b1;
            cycle_count <= '0;
          end
        end
        LOAD: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
        RUN: begin
          cycle_count <= count_next;
          if (done) begin
            state   <= FINISH;
            run_en  <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b0;
          end else if (count_next == MAX_C) begin
            state   <= FINISH;
            run_en  <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b1;
          end
        end
        FINISH: begin
          if (start) begin
            state         <= HOLD;
            ack           <= 1'b0;
            timeout       <= 1'b0;
            pc_load_value <= prog_base;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a run-level reference model compared every
// cycle, plus hand-computed checks for each scenario.
module tb_run_controller;

  localparam int CNT_W = 16;
  localparam int MAX   = 50;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  prog_base;
  logic             done;
  logic             run_en;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_value;
  logic             ack;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  run_controller #(.CNT_W(CNT_W), .MAX_CYCLES(MAX), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_base(prog_base), .done(done),
    .run_en(run_en), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .ack(ack), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: what a run looks like from the outside.
  bit          m_armed, m_capturing, m_loading, m_running, m_finished, m_to;
  int          m_count;
  logic [31:0] m_base;

  task automatic model_reset();
    m_armed = 0; m_capturing = 0; m_loading = 0; m_running = 0;
    m_finished = 0; m_to = 0; m_count = 0; m_base = '0;
  endtask

  task automatic model_step();
    if (m_running) begin
      m_count++;
      if (done) begin
        m_running = 0; m_finished = 1; m_to = 0;
      end else if (m_count == MAX) begin
        m_running = 0; m_finished = 1; m_to = 1;
      end
    end else if (m_loading) begin
      m_loading = 0; m_running = 1;
    end else if (m_capturing) begin
      if (start) m_base = prog_base;
      else begin
        m_capturing = 0; m_loading = 1; m_count = 0;
      end
    end else if (start && m_armed) begin
      m_capturing = 1; m_base = prog_base; m_finished = 0; m_to = 0;
    end
    m_armed = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_step();
    end
  end

  always @(negedge clk) begin
    chk("cmp_run_en", run_en, m_running);
    chk("cmp_pc_load", pc_load, m_loading);
    chk("cmp_pc_load_value", pc_load_value, m_base);
    chk("cmp_ack", ack, m_finished);
    chk("cmp_timeout", timeout, m_to);
    chk("cmp_cycle_count", cycle_count, 64'(m_count));
  end

  int run_cnt = 0;
  int pcl_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (run_en)  run_cnt++;
      if (pc_load) pcl_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int run0, pcl0;

  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; prog_base = '0;
    #1 reset = 1'b0;
    model_reset();
    step(2);
    chk("reset_run_en", run_en, 0);
    chk("reset_ack", ack, 0);
    chk("reset_pc_load_value", pc_load_value, 0);
    chk("reset_cycle_count", cycle_count, 0);

    // Basic run: start raised on the release edge, held 3 cycles
    reset = 1'b1; start = 1'b1; prog_base = 32'h10;
    step(1);
    chk("release_edge_stays_idle", pc_load_value, 0);
    step(2);
    run0 = run_cnt; pcl0 = pcl_cnt;
    start = 1'b0;
    step(1);
    chk("basic_pc_load", pc_load, 1);
    chk("basic_pc_load_value", pc_load_value, 32'h10);
    chk("basic_load_run_en", run_en, 0);
    step(1);
    chk("basic_first_run", run_en, 1);
    step(4);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("basic_ack", ack, 1);
    chk("basic_timeout", timeout, 0);
    chk("basic_count", cycle_count, 5);
    chk("basic_run_len", run_cnt - run0, 5);
    chk("basic_pc_load_pulses", pcl_cnt - pcl0, 1);
    step(3);
    chk("basic_ack_held", ack, 1);

    // Re-run with done during HOLD/LOAD, start glitches in RUN, then watchdog
    prog_base = 32'h40; start = 1'b1; done = 1'b1;
    step(1);
    chk("rerun_ack_drop", ack, 0);
    start = 1'b0;
    run0 = run_cnt;
    step(1);
    chk("rerun_pc_load", pc_load, 1);
    chk("rerun_value", pc_load_value, 32'h40);
    chk("rerun_count_clear", cycle_count, 0);
    step(1);
    done = 1'b0;
    chk("rerun_running", run_en, 1);
    start = 1'b1;
    step(1);
    chk("rerun_count_from_1", cycle_count, 1);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("glitch_run_en", run_en, 1);
    chk("glitch_count", cycle_count, 3);
    for (int i = 0; i < 120 && run_en; i++) step(1);
    chk("wd_ended_in_time", run_en, 0);
    chk("wd_run_len", run_cnt - run0, MAX);
    chk("wd_ack", ack, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_count", cycle_count, MAX);
    step(20);
    chk("wd_count_held", cycle_count, MAX);

    // Tie: done on the budget cycle
    prog_base = 32'h80; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    step(MAX - 1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("tie_ack", ack, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_count", cycle_count, MAX);

    // Reset mid-run on RUN cycle 7
    prog_base = 32'h20; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    step(6);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_run_en", run_en, 0);
    chk("midrst_count", cycle_count, 0);
    chk("midrst_value", pc_load_value, 0);
    chk("midrst_ack", ack, 0);
    step(1);
    reset = 1'b1;
    step(3);
    chk("post_rst_ack", ack, 0);
    chk("post_rst_run_en", run_en, 0);

    // done glitch in IDLE
    done = 1'b1;
    step(2);
    done = 1'b0;
    step(1);
    chk("idle_done_run_en", run_en, 0);
    chk("idle_done_count", cycle_count, 0);
    chk("idle_done_pc_load", pc_load, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
